// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with sticky ready, framing and overrun flags
//   clk     : system clock, all logic on posedge
//   rst     : asynchronous active-high reset
//   RX      : asynchronous serial input, idle high
//   clr_rdy : consumer has taken rx_data; clears rdy, frm_err, ovr_err
//   rx_data : last received byte, held until the next frame completes
//   rdy     : byte available, sticky until clr_rdy
//   frm_err : last completed frame had a low stop bit
//   ovr_err : a frame completed while rdy was still set
module uart_rx #(
  parameter int BAUD_CYCLES = 2604,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);
  localparam int CW = $clog2(BAUD_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(BAUD_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   w_rx_s;
  logic                   w_strobe;
  assign w_rx_s   = r_sync[SYNC_STAGES-1];
  assign w_strobe = (r_cnt == '0) && (r_state != IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      // Clear first so that a coincident frame completion below overrides it.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
      end
      if (r_state != IDLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        IDLE: if (!w_rx_s) begin
          r_cnt   <= HALF;
          r_bit   <= '0;
          r_state <= START;
        end
        START: if (w_strobe) begin
          r_cnt   <= FULL;
          r_state <= w_rx_s ? IDLE : DATA;
        end
        DATA: if (w_strobe) begin
          r_shift <= {w_rx_s, r_shift[7:1]};
          r_bit   <= r_bit + 4'd1;
          r_cnt   <= FULL;
          if (r_bit == 4'd7) r_state <= STOP;
        end
        STOP: if (w_strobe) begin
          // Complete at mid stop bit so a following start edge is not missed.
          rx_data <= r_shift;
          rdy     <= 1'b1;
          frm_err <= ~w_rx_s;
          ovr_err <= ovr_err | rdy;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a bit-level serial driver
module tb_uart_rx;
  localparam int B = 32;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  int         n_chk = 0;
  int         n_err = 0;
  int         n;
  uart_rx #(.BAUD_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RX = bits[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
  endtask
  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] d, input logic r, input logic f, input logic o);
    chk({tag, "_data"}, rx_data, d);
    chk({tag, "_rdy"}, rdy, r);
    chk({tag, "_frm"}, frm_err, f);
    chk({tag, "_ovr"}, ovr_err, o);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_frame("rst", 8'h00, 0, 0, 0);
    rst = 1'b0;
    repeat (10 * B) @(negedge clk);
    chk_frame("idle", 8'h00, 0, 0, 0);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 10);
      while (!rdy && n < 1000) begin
        @(negedge clk);
        n++;
      end
    join
    chk("a5_lat_ok", 8'(n >= 2 + B * 19 / 2 - 2 && n <= 2 + B * 19 / 2 + 2), 8'd1);
    chk_frame("a5", 8'hA5, 1, 0, 0);
    pulse_clr();
    chk_frame("a5_clr", 8'hA5, 0, 0, 0);
    send_frame(8'h00, 1'b1, 10);
    chk_frame("b00", 8'h00, 1, 0, 0);
    pulse_clr();
    chk("b00_clr", rdy, 1'b0);
    send_frame(8'hFF, 1'b1, 10);
    chk_frame("bff", 8'hFF, 1, 0, 0);
    pulse_clr();
    chk("bff_clr", rdy, 1'b0);
    send_frame(8'h55, 1'b1, 10);
    chk_frame("b55", 8'h55, 1, 0, 0);
    pulse_clr();
    chk("b55_clr", rdy, 1'b0);
    send_frame(8'h3C, 1'b0, 10);
    chk_frame("frm", 8'h3C, 1, 1, 0);
    pulse_clr();
    chk_frame("frm_clr", 8'h3C, 0, 0, 0);
    repeat (2 * B) @(negedge clk);
    chk("frm_nofalse", rdy, 1'b0);
    send_frame(8'h11, 1'b1, 10);
    chk_frame("o11", 8'h11, 1, 0, 0);
    send_frame(8'h22, 1'b1, 10);
    chk_frame("o22", 8'h22, 1, 0, 1);
    // Completion edge is 307 edges after the start bit is driven with this driver.
    fork
      send_frame(8'h33, 1'b1, 10);
      begin
        repeat (306) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    chk_frame("o33", 8'h33, 1, 0, 1);
    pulse_clr();
    chk_frame("o33_clr", 8'h33, 0, 0, 0);
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk_frame("glitch", 8'h33, 0, 0, 0);
    send_frame(8'h81, 1'b1, 5);
    rst = 1'b1;
    #1;
    chk_frame("rst_mid", 8'h00, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * B) @(negedge clk);
    chk_frame("rst_discard", 8'h00, 0, 0, 0);
    send_frame(8'h7E, 1'b1, 10);
    chk_frame("r7e", 8'h7E, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive counterpart to the team's UART transmitter. It uses the same bit timing: 50 MHz clk, BAUD_CYCLES clocks per bit, LSB first, one start bit (0), 8 data bits, one stop bit (1). It deserializes the RX line into a byte and raises rdy. It flags framing and overrun errors, and it sits between the pad-side RX pin and the command/packet logic.

Parameters:
BAUD_CYCLES, 2604, clk cycles per bit (50 MHz / 19200 baud); must be >= 16 and even
SYNC_STAGES, 2, metastability flops on RX; fixed at 2 for this revision

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
RX  input  1  asynchronous serial input, idle high
clr_rdy  input  1  single-cycle pulse; consumer has taken rx_data; clears rdy, frm_err, ovr_err
rx_data  output  8  last received byte, stable while rdy=1 until next frame completes
rdy  output  1  byte available; sticky until clr_rdy
frm_err  output  1  sticky; last completed frame had stop bit = 0
ovr_err  output  1  sticky; a frame completed while rdy was still 1

Behaviour:
- Reset (async, rst=1): sync flops preset to 1; state=IDLE; rx_data=8'h00; rdy=0; frm_err=0; ovr_err=0; counters 0.
- rx_s = RX after 2 flops; all decisions use rx_s only (2-cycle input latency).
- Baud counter: down-counter, width ceil(log2(BAUD_CYCLES)); sample strobe when it is 0 and state != IDLE.
- Bit counter: 4 bits; counts data bits 0..7.
- Shift register: 8 bits; on each data sample, rx_s enters at MSB and the register shifts right, so bit 0 (first received) ends in rx_data[0].
- FSM states and transitions:
  - IDLE: on rx_s==0, load baud counter with BAUD_CYCLES/2-1, clear bit counter, go START.
  - START: at strobe (mid start bit), if rx_s==1 it is a glitch: go IDLE, no flags change. Else reload BAUD_CYCLES-1 and go DATA.
  - DATA: at each strobe, shift in rx_s, increment the bit counter, reload BAUD_CYCLES-1. After the 8th shift go STOP.
  - STOP: at strobe (mid stop bit), complete the frame (see next bullet), then go IDLE in the same cycle. Do not wait for the end of the stop bit; this allows back-to-back frames.
- Frame completion (single cycle):
  - rx_data <= shift register.
  - rdy <= 1.
  - frm_err <= ~rx_s.
  - ovr_err <= ovr_err | rdy (rdy value before this cycle).
  - The byte is delivered even on a framing error.
- clr_rdy: clears rdy, frm_err, ovr_err on the next edge. If clr_rdy coincides with frame completion, completion wins: rdy=1, and frm_err/ovr_err take the completion values, with ovr_err computed from the pre-clear rdy.
- clr_rdy while IDLE with rdy=0 has no effect. clr_rdy never affects an in-progress frame.
- Latency: RX falls at cycle 0. The start-bit sample occurs at cycle 2+BAUD_CYCLES/2 (±1). The stop sample and rdy rise occur at cycle 2+BAUD_CYCLES/2+9*BAUD_CYCLES (±1).
- Line held low (break): it is received as 8'h00 with frm_err=1. The FSM returns to IDLE, sees rx_s==0, and restarts immediately. Each restart produces one frame per 9.5 bit times; this behaviour is required, not suppressed.
- Reset asserted mid-frame: immediate return to reset values. A partial frame is discarded with no rdy pulse.
- rx_data changes only at frame completion or reset.

Test Plan:
- Reset, RX=1 idle for 10*BAUD_CYCLES -> rdy=0, rx_data=8'h00, frm_err=0, ovr_err=0, state stays IDLE.
- Drive frame 0xA5, stop=1, from the team's transmitter looped back -> rdy rises at 2+BAUD_CYCLES*9.5 ±2 cycles, rx_data=8'hA5, frm_err=0. Then clr_rdy pulse -> rdy=0 next cycle, rx_data holds 8'hA5.
- Back-to-back frames 0x00, 0xFF, 0x55 with clr_rdy after each -> three rdy pulses, bytes correct in order, no errors.
- Frame 0x3C with stop bit forced 0 -> rx_data=8'h3C, rdy=1, frm_err=1. Following clr_rdy clears both.
- Frame 0x11, no clr_rdy, then frame 0x22 -> rx_data=8'h22, rdy=1, ovr_err=1. clr_rdy issued on the exact completion cycle of a third frame 0x33 -> rdy=1, ovr_err=1, rx_data=8'h33.
- Two cases:
  - RX low glitch of BAUD_CYCLES/4 cycles -> no rdy, back to IDLE.
  - rst asserted mid-DATA of frame 0x81, released, then a clean 0x7E -> outputs at reset values during rst; then rx_data=8'h7E, no errors.
